// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS instructions into 32-bit words and writes them to consecutive imem word addresses.
// Latency 1 from in_valid&&in_ready to imem_we; in_ready drops while a written word waits on imem_ready.
module mips_instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          base_pc,
    input  logic                 finish,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           op_sel,
    input  logic [4:0]           rs,
    input  logic [4:0]           rt,
    input  logic [4:0]           rd,
    input  logic [4:0]           shamt,
    input  logic [15:0]          imm,
    input  logic [31:0]          target,
    output logic                 imem_we,
    input  logic                 imem_ready,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [31:0]          imem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 full,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [31:0]          err_pc
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc4, diff, word;
    logic [5:0]  funct, opcode;
    logic        reject, accept, write, last, load, const_shift;

    assign pc4         = pc + 32'd4;
    assign diff        = target - pc4;
    assign in_ready    = (state == RUN) && (!imem_we || imem_ready);
    assign accept      = in_valid && in_ready;
    assign write       = accept && !reject;
    assign last        = (pc[ADDR_W+1:2] == {ADDR_W{1'b1}});
    assign load        = start && ((state == IDLE) || (state == DONE));
    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);
    assign const_shift = (op_sel == 5'd10) || (op_sel == 5'd11) || (op_sel == 5'd12);

    always_comb begin
        funct  = 6'd0;
        opcode = 6'd0;
        case (op_sel)
            5'd0:  funct  = 6'b100000;
            5'd1:  funct  = 6'b100001;
            5'd2:  funct  = 6'b100010;
            5'd3:  funct  = 6'b100011;
            5'd4:  funct  = 6'b100100;
            5'd5:  funct  = 6'b100101;
            5'd6:  funct  = 6'b100110;
            5'd7:  funct  = 6'b100111;
            5'd8:  funct  = 6'b101010;
            5'd9:  funct  = 6'b101011;
            5'd10: funct  = 6'b000000;
            5'd11: funct  = 6'b000010;
            5'd12: funct  = 6'b000011;
            5'd13: funct  = 6'b000100;
            5'd14: funct  = 6'b000110;
            5'd15: funct  = 6'b000111;
            5'd16: funct  = 6'b001000;
            5'd17: opcode = 6'b100011;
            5'd18: opcode = 6'b101011;
            5'd19: opcode = 6'b000100;
            5'd20: opcode = 6'b000101;
            5'd21: opcode = 6'b000001;
            5'd22: opcode = 6'b001000;
            5'd23: opcode = 6'b001001;
            5'd24: opcode = 6'b001100;
            5'd25: opcode = 6'b001101;
            5'd26: opcode = 6'b001110;
            5'd27: opcode = 6'b001010;
            5'd28: opcode = 6'b001011;
            5'd29: opcode = 6'b000010;
            5'd30: opcode = 6'b000011;
            default: opcode = 6'b001111;
        endcase
    end

    // Branch offsets must fit the signed 18-bit byte range; jumps must stay in the pc+4 256 MB region.
    always_comb begin
        word   = 32'd0;
        reject = 1'b0;
        if (!op_sel[4]) begin
            word = {6'd0, const_shift ? 5'd0 : rs, rt, rd, const_shift ? shamt : 5'd0, funct};
        end else if (op_sel == 5'd16) begin
            word = {6'd0, rs, 15'd0, funct};
        end else if ((op_sel == 5'd19) || (op_sel == 5'd20) || (op_sel == 5'd21)) begin
            word   = {opcode, rs, (op_sel == 5'd21) ? 5'd1 : rt, diff[17:2]};
            reject = (target[1:0] != 2'b00) || (diff[31:17] != {15{diff[17]}});
        end else if ((op_sel == 5'd29) || (op_sel == 5'd30)) begin
            word   = {opcode, target[27:2]};
            reject = (target[1:0] != 2'b00) || (target[31:28] != pc4[31:28]);
        end else begin
            word = {opcode, (op_sel == 5'd31) ? 5'd0 : rs, rt, imm};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (finish || (write && last)) state_nxt = DRAIN;
            DRAIN:   if (!imem_we) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= 32'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            full       <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
            err_pc     <= 32'd0;
        end else begin
            if (load) begin
                pc      <= {base_pc[31:2], 2'b00};
                full    <= 1'b0;
                err     <= 1'b0;
                err_cnt <= '0;
                err_pc  <= 32'd0;
            end
            if (write) begin
                imem_we    <= 1'b1;
                imem_wdata <= word;
                imem_addr  <= pc[ADDR_W+1:2];
                pc         <= pc4;
                if (last) full <= 1'b1;
            end else if (imem_ready) begin
                imem_we <= 1'b0;
            end
            if (accept && reject) begin
                err <= 1'b1;
                if (!err) err_pc <= pc;
                if (err_cnt != {ERR_CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed vectors, stall, full, reset and randomized batches.
module tb_mips_instr_encoder;
    localparam int AW = 4;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, finish = 1'b0, in_valid = 1'b0, imem_ready = 1'b1;
    logic [31:0]   base_pc = '0, target = '0;
    logic [4:0]    op_sel = '0, rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0]   imm = '0;
    logic          in_ready, imem_we, busy, done, full, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata, err_pc;
    logic [7:0]    err_cnt;

    mips_instr_encoder #(.ADDR_W(AW), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_pc(base_pc), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .imm(imm), .target(target), .imem_we(imem_we), .imem_ready(imem_ready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done), .full(full),
        .err(err), .err_cnt(err_cnt), .err_pc(err_pc)
    );

    always #5 clk = ~clk;

    typedef struct {logic [AW-1:0] a; logic [31:0] d;} wr_t;
    wr_t         sb[$];
    wr_t         exp_wr;
    int          total = 0, bad = 0, wr_cnt = 0;
    int unsigned m_pc = 0, m_errpc = 0, m_cnt = 0;
    bit          m_err = 0, held = 0, rnd_on = 0;
    logic [31:0] held_d;
    logic [AW-1:0] held_a;

    // funct for ops 0..16, major opcode for ops 17..31
    int unsigned code_tab [32] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 8,
                                   35, 43, 4, 5, 1, 8, 9, 12, 13, 14, 10, 11, 2, 3, 15};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void ref_enc(input int unsigned op, rs_, rt_, rd_, sh_, im, tg, pc,
                                    output int unsigned w, output bit ok);
        int unsigned nxt = pc + 4;
        int          d   = int'(tg - nxt);
        int unsigned r, s;
        ok = 1;
        w  = 0;
        if (op < 16) begin
            r = rs_;
            s = 0;
            if (op >= 10 && op <= 12) begin r = 0; s = sh_; end
            w = (r << 21) | (rt_ << 16) | (rd_ << 11) | (s << 6) | code_tab[op];
        end else if (op == 16) begin
            w = (rs_ << 21) | code_tab[16];
        end else if (op >= 19 && op <= 21) begin
            ok = (tg % 4 == 0) && (d >= -131072) && (d < 131072);
            w  = (code_tab[op] << 26) | (rs_ << 21) | ((op == 21 ? 32'd1 : rt_) << 16)
               | (int'(d / 4) & 32'hFFFF);
        end else if (op == 29 || op == 30) begin
            ok = (tg % 4 == 0) && ((tg >> 28) == (nxt >> 28));
            w  = (code_tab[op] << 26) | ((tg >> 2) & 32'h03FF_FFFF);
        end else begin
            w = (code_tab[op] << 26) | ((op == 31 ? 32'd0 : rs_) << 21) | (rt_ << 16) | (im & 32'hFFFF);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 0;
        end else begin
            if (held) begin
                chk("hold_we", {31'd0, imem_we}, 32'd1);
                chk("hold_data", imem_wdata, held_d);
                chk("hold_addr", {28'd0, imem_addr}, {28'd0, held_a});
            end
            held = 0;
            if (imem_we && imem_ready) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %h data %h with nothing expected", imem_addr, imem_wdata);
                end else begin
                    exp_wr = sb.pop_front();
                    chk("wr_addr", {28'd0, imem_addr}, {28'd0, exp_wr.a});
                    chk("wr_data", imem_wdata, exp_wr.d);
                end
            end else if (imem_we) begin
                held   = 1;
                held_d = imem_wdata;
                held_a = imem_addr;
            end
        end
    end

    task automatic send(input int unsigned op, r_s, r_t, r_d, sh, im, tg, input bit exp_acc);
        bit          acc = 0;
        bit          ok;
        int          n   = 0;
        int unsigned w;
        op_sel = op[4:0]; rs = r_s[4:0]; rt = r_t[4:0]; rd = r_d[4:0]; shamt = sh[4:0];
        imm = im[15:0]; target = tg; in_valid = 1'b1;
        while (!acc && n < 40) begin
            @(negedge clk);
            if (in_ready) acc = 1; else n++;
        end
        if (acc) begin
            ref_enc(op, r_s, r_t, r_d, sh, im, tg, m_pc, w, ok);
            if (ok) begin
                sb.push_back('{a: m_pc[AW+1:2], d: w});
                m_pc += 4;
            end else begin
                if (!m_err) m_errpc = m_pc;
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (acc != exp_acc) begin
            bad++;
            $display("FAIL accept op=%0d: accepted=%0d want %0d", op, acc, exp_acc);
        end
    endtask

    task automatic do_start(input int unsigned b);
        start = 1'b1; base_pc = b;
        @(posedge clk); #1;
        start = 1'b0;
        m_pc = b & ~32'd3; m_err = 0; m_cnt = 0; m_errpc = 0;
    endtask

    task automatic do_finish();
        int n = 0;
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        chk("done", {31'd0, done}, 32'd1);
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("err_cnt", {24'd0, err_cnt}, m_cnt);
        chk("err_pc", err_pc, m_errpc);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic rand_instr();
        int unsigned op = $urandom_range(0, 31), nxt = m_pc + 4, kind = $urandom_range(0, 3), tg;
        tg = $urandom;
        if (op >= 19 && op <= 21) begin
            case (kind)
                0, 1:    tg = nxt + 4 * $urandom_range(0, 400) - 800;
                2:       case ($urandom_range(0, 3))
                             0: tg = nxt + 32'h1FFFC;
                             1: tg = nxt + 32'h20000;
                             2: tg = nxt - 32'h20000;
                             default: tg = nxt - 32'h20004;
                         endcase
                default: tg = nxt + $urandom_range(1, 3);
            endcase
        end else if (op == 29 || op == 30) begin
            case (kind)
                0, 1:    tg = (nxt & 32'hF000_0000) | ($urandom & 32'h0FFF_FFFC);
                2:       tg = $urandom & ~32'd3;
                default: tg = (nxt & 32'hF000_0000) | ($urandom & 32'h0FFF_FFFC) | 32'd2;
            endcase
        end
        send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), tg, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", {28'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_err_pc", err_pc, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_start(0);
        chk("busy_run", {31'd0, busy}, 32'd1);
        send(0, 1, 2, 3, 0, 0, 0, 1);
        chk("add_we", {31'd0, imem_we}, 32'd1);
        chk("add_addr", {28'd0, imem_addr}, 32'd0);
        chk("add_word", imem_wdata, 32'h0022_1820);
        do_finish();

        do_start(0);
        send(17, 29, 8, 0, 0, 4, 0, 1);
        chk("lw_word", imem_wdata, 32'h8FA8_0004);
        send(10, 7, 1, 2, 4, 0, 0, 1);
        chk("sll_addr", {28'd0, imem_addr}, 32'd1);
        chk("sll_word", imem_wdata, 32'h0001_1100);
        do_finish();

        do_start(0);
        send(19, 1, 2, 0, 0, 0, 32'h12, 1);
        chk("beq_rej_we", {31'd0, imem_we}, 32'd0);
        chk("beq_rej_err", {31'd0, err}, 32'd1);
        chk("beq_rej_cnt", {24'd0, err_cnt}, 32'd1);
        chk("beq_rej_pc", err_pc, 32'd0);
        send(19, 1, 2, 0, 0, 0, 32'h10, 1);
        chk("beq_addr", {28'd0, imem_addr}, 32'd0);
        chk("beq_word", imem_wdata, 32'h1022_0003);
        do_finish();

        do_start(32'h0040_0000);
        send(29, 0, 0, 0, 0, 0, 32'h0040_0018, 1);
        chk("j_word", imem_wdata, 32'h0810_0006);
        send(29, 0, 0, 0, 0, 0, 32'h1000_0000, 1);
        chk("j_rej_cnt", {24'd0, err_cnt}, 32'd1);
        do_finish();

        do_start(0);
        imem_ready = 1'b0;
        fork
            begin
                send(2, 4, 5, 6, 0, 0, 0, 1);
                send(6, 7, 8, 9, 0, 0, 0, 1);
            end
            begin
                int n = 0;
                while (!imem_we && n < 10) begin @(negedge clk); n++; end
                chk("stall_rdy0", {31'd0, in_ready}, 32'd0);
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_rdy", {31'd0, in_ready}, 32'd0);
                end
                @(posedge clk); #1;
                imem_ready = 1'b1;
            end
        join
        do_finish();

        do_start(0);
        for (int i = 0; i < 16; i++) send(1, i, i + 1, i + 2, 0, 0, 0, 1);
        send(1, 3, 3, 3, 0, 0, 0, 0);
        chk("full", {31'd0, full}, 32'd1);
        chk("full_done", {31'd0, done}, 32'd1);
        chk("full_sb_empty", sb.size(), 0);

        imem_ready = 1'b0;
        do_start(32'h48);
        send(0, 1, 1, 1, 0, 0, 0, 1);
        chk("pre_rst_we", {31'd0, imem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", {31'd0, imem_we}, 32'd0);
        chk("arst_wdata", imem_wdata, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        imem_ready = 1'b1;
        do_start(32'h48);
        send(0, 4, 5, 6, 0, 0, 0, 1);
        chk("resume_addr", {28'd0, imem_addr}, 32'd2);
        chk("resume_word", imem_wdata, 32'h0085_3020);
        do_finish();

        do_start(32'h200);
        for (int i = 0; i < 260; i++) send(29, 0, 0, 0, 0, 0, 32'h1, 1);
        chk("sat_cnt", {24'd0, err_cnt}, 32'hFF);
        do_finish();

        rnd_on = 1;
        fork
            begin
                for (int b = 0; b < 10; b++) begin
                    do_start($urandom & 32'hFFFF_FFC0);
                    for (int k = 0, lim = $urandom_range(4, 12); k < lim; k++) rand_instr();
                    do_finish();
                end
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    imem_ready = ($urandom_range(0, 3) != 0);
                end
                imem_ready = 1'b1;
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Encoder and writer counterpart of the core's instruction decoder. It accepts symbolic instructions over a valid/ready stream and encodes each into a 32-bit MIPS word.
- Each word is written into instruction memory at consecutive word addresses. Branch and jump targets are converted to offset and index fields.
- Sits between the test or boot loader and the instruction memory write port. It covers exactly the instruction set the control unit decodes.

Parameters:
ADDR_W, 8, instruction memory word-address width; depth = 2^ADDR_W words
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; loads pc from base_pc, enters RUN
base_pc  in  32  byte start address, bits[1:0] ignored
finish  in  1  pulse; stop accepting, drain, go DONE
in_valid  in  1  instruction present
in_ready  out  1  encoder accepts this cycle
op_sel  in  5  0 ADD,1 ADDU,2 SUB,3 SUBU,4 AND,5 OR,6 XOR,7 NOR,8 SLT,9 SLTU,10 SLL,11 SRL,12 SRA,13 SLLV,14 SRLV,15 SRAV,16 JR,17 LW,18 SW,19 BEQ,20 BNE,21 BGEZ,22 ADDI,23 ADDIU,24 ANDI,25 ORI,26 XORI,27 SLTI,28 SLTIU,29 J,30 JAL,31 LUI
rs, rt, rd, shamt  in  5 each  register and shift fields
imm  in  16  immediate for I-type ALU, LW, SW and LUI
target  in  32  byte target address for BEQ, BNE, BGEZ, J and JAL
imem_we  out  1  write strobe, held until imem_ready
imem_ready  in  1  memory accepts the write
imem_addr  out  ADDR_W  word address (pc[ADDR_W+1:2])
imem_wdata  out  32  encoded word
busy  out  1  state is RUN or DRAIN
done  out  1  state is DONE
full  out  1  last word address consumed
err  out  1  sticky encode error
err_cnt  out  ERR_CNT_W  saturating count of rejected instructions
err_pc  out  32  pc of the first rejected instruction

Behaviour:
- Reset values: all outputs 0; state IDLE; pc 0.
- States:
  - IDLE: start -> RUN; pc = {base_pc[31:2],2'b00}; clears err, err_cnt, err_pc and full.
  - RUN: finish, or acceptance of the word at index 2^ADDR_W-1 -> DRAIN. The last-word case also sets full.
  - DRAIN: output stage empty -> DONE.
  - DONE: start -> RUN, same load as from IDLE.
- start while RUN or DRAIN is ignored. finish outside RUN is ignored.
- in_ready = (state==RUN) && (!imem_we || imem_ready).
- An instruction is accepted on in_valid && in_ready. Its word appears on imem_we/imem_wdata/imem_addr the next cycle (latency 1). The word is held stable until imem_ready.
- Back-to-back: with imem_ready tied 1, one word is written per cycle.
- R-type word = {000000, rs, rt, rd, shamt, funct}.
  - funct: ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111.
  - SLL, SRL and SRA force rs=0. Non-shift ops force shamt=0.
  - JR = {000000, rs, 15'b0, 001000}.
- I-type word = {opcode, rs, rt, imm}.
  - opcodes: LW 100011, SW 101011, ADDI 001000, ADDIU 001001, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, SLTIU 001011, LUI 001111.
  - LUI forces rs=0.
- Branches (BEQ 000100, BNE 000101, BGEZ 000001 with rt forced to 00001):
  - diff = target - (pc+4), in 32-bit two's complement.
  - The instruction is rejected if target[1:0] != 0, or if diff[31:17] is not all equal to diff[17].
  - Otherwise imm field = diff[17:2].
- J (000010) and JAL (000011):
  - The instruction is rejected if target[1:0] != 0 or target[31:28] != (pc+4)[31:28].
  - Otherwise word = {opcode, target[27:2]}.
- Rejected instruction:
  - It is still consumed (in_ready handshake completes), but no write is issued and pc does not advance.
  - err is set to 1, and err_cnt increments, saturating at all-ones.
  - err_pc captures the pc only on the first error.
- pc advances by 4 on each accepted, non-rejected instruction. A word written to index 2^ADDR_W-1 ends RUN; there is no wrap-around.
- Reset mid-write drops the pending word, and imem_we deasserts immediately (asynchronous).
- finish and in_valid in the same RUN cycle: the instruction is accepted, then the block drains.

Test Plan:
- start, base_pc=0; ADD rs=1 rt=2 rd=3 -> imem_we next cycle, addr 0, wdata 0x00221820.
- LW rs=29 rt=8 imm=4, then SLL rt=1 rd=2 shamt=4 (rs input 7) -> 0x8FA80004 at addr 0, 0x00011100 at addr 1.
- pc=0: BEQ rs=1 rt=2 target=0x10 -> 0x10220003. Same with target=0x12 -> no write; err=1, err_cnt=1, err_pc=0; next valid instruction still written at addr 0.
- base_pc=0x00400000: J target=0x00400018 -> 0x08100006. J target=0x10000000 -> rejected.
- Hold imem_ready=0 for 3 cycles with 2 instructions queued -> in_ready=0, wdata stable, no loss; release -> 2 writes in order.
- ADDR_W=2, 5 instructions -> 4 writes, full=1, done=1, 5th not accepted. Separately, assert rst_n low while imem_we is high -> all outputs 0; after start, writing resumes at base_pc.
